esched_ctrl: RTL and testbench



---
 rtl/galaga_lib.sv | 23 ++
 rtl/esched_step_timer.sv | 63 ++++++
 rtl/esched_ctrl.sv | 105 ++++++++++
 tb/tb_esched_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/galaga_lib.sv
// Shared constants and state type for the enemy-ship schedule path.
package galaga_lib;

    localparam int unsigned NM          = 8;
    localparam int unsigned ENEMY_N     = 8;
    localparam int unsigned HOLD_FRAMES = 16;
    localparam int unsigned MIN_HOLD    = 4;
    localparam int unsigned START_DELAY = 60;

    localparam int unsigned IDX_W    = 10;
    localparam int unsigned WAVE_W   = 4;
    localparam int unsigned WAVE_MAX = 15;
    localparam int unsigned HOLD_W   = 6;
    localparam int unsigned INTRO_W  = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INTRO = 2'd1,
        S_RUN   = 2'd2,
        S_CLEAR = 2'd3
    } esched_state_e;

endpackage

// File: rtl/esched_step_timer.sv
// Per-entry hold timer and wrap-around schedule index.
//   frame_clk, Reset : clock and synchronous active-high reset
//   en               : advance the hold counter this frame
//   clr              : force hold counter and index to 0 (wins over en)
//   wave_num         : current wave, sets the per-entry hold length
//   index            : registered schedule index, 0..NM-1
//   step_c           : combinational pulse on the frame the index advances
module esched_step_timer
    import galaga_lib::*;
(
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic              en,
    input  logic              clr,
    input  logic [WAVE_W-1:0] wave_num,
    output logic [IDX_W-1:0]  index,
    output logic              step_c
);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [HOLD_W-1:0] dbl_wave_c;
    logic [HOLD_W-1:0] cur_hold_c;

    // cur_hold = max(HOLD_FRAMES - 2*wave, MIN_HOLD), clamped before subtracting
    always_comb begin
        dbl_wave_c = {1'b0, wave_num, 1'b0};
        if (dbl_wave_c >= HOLD_W'(HOLD_FRAMES - MIN_HOLD))
            cur_hold_c = HOLD_W'(MIN_HOLD);
        else
            cur_hold_c = HOLD_W'(HOLD_FRAMES) - dbl_wave_c;
    end

    assign step_c = en && !clr && (hold_q == cur_hold_c - HOLD_W'(1));

    // Hold counter and index next-state
    always_comb begin
        hold_d  = hold_q;
        index_d = index_q;
        if (clr) begin
            hold_d  = '0;
            index_d = '0;
        end else if (step_c) begin
            hold_d  = '0;
            index_d = (index_q == IDX_W'(NM - 1)) ? '0 : index_q + IDX_W'(1);
        end else if (en) begin
            hold_d  = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            hold_q  <= '0;
            index_q <= '0;
        end else begin
            hold_q  <= hold_d;
            index_q <= index_d;
        end
    end

    assign index = index_q;

endmodule

// File: rtl/esched_ctrl.sv
// Enemy-ship schedule sequencer: idle, intro delay, running schedule, wave clear.
//   frame_clk, Reset : frame clock and synchronous active-high reset
//   game_start       : start request, honoured only in IDLE
//   pause            : freezes schedule progress in RUN
//   alive_mask       : per-enemy alive flags; all-zero clears the wave
//   ESchedCtr        : schedule index for the location stages
//   sched_active     : high while the schedule runs
//   wave_num         : current wave, saturating at 15
//   wave_done        : one-frame pulse when a wave is cleared
module esched_ctrl
    import galaga_lib::*;
(
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               game_start,
    input  logic               pause,
    input  logic [ENEMY_N-1:0] alive_mask,
    output logic [IDX_W-1:0]   ESchedCtr,
    output logic               sched_active,
    output logic [WAVE_W-1:0]  wave_num,
    output logic               wave_done
);

    esched_state_e      state_q, state_d;
    logic [INTRO_W-1:0] intro_cnt_q, intro_cnt_d;
    logic [WAVE_W-1:0]  wave_num_q, wave_num_d;
    logic               sched_active_q, sched_active_d;
    logic               wave_done_q, wave_done_d;
    logic               timer_en_c;
    logic               timer_clr_c;
    logic               step_unused_c;

    // Next-state and registered-output decode
    always_comb begin
        state_d        = state_q;
        intro_cnt_d    = intro_cnt_q;
        wave_num_d     = wave_num_q;
        case (state_q)
            S_IDLE: begin
                if (game_start) begin
                    state_d     = S_INTRO;
                    intro_cnt_d = '0;
                end
            end
            S_INTRO: begin
                if (intro_cnt_q == INTRO_W'(START_DELAY - 1)) begin
                    state_d     = S_RUN;
                    intro_cnt_d = '0;
                end else begin
                    intro_cnt_d = intro_cnt_q + INTRO_W'(1);
                end
            end
            S_RUN: begin
                // Empty mask wins over pause and any step in the same frame
                if (alive_mask == '0) begin
                    state_d    = S_CLEAR;
                    wave_num_d = (wave_num_q == WAVE_W'(WAVE_MAX)) ? wave_num_q
                                                                    : wave_num_q + WAVE_W'(1);
                end
            end
            S_CLEAR: begin
                state_d     = S_INTRO;
                intro_cnt_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        sched_active_d = (state_d == S_RUN);
        wave_done_d    = (state_d == S_CLEAR);
    end

    // Timer advances only on RUN frames that stay in RUN; anything else parks it at 0
    assign timer_en_c  = (state_q == S_RUN) && (state_d == S_RUN) && !pause;
    assign timer_clr_c = (state_d != S_RUN);

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            intro_cnt_q    <= '0;
            wave_num_q     <= '0;
            sched_active_q <= 1'b0;
            wave_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            intro_cnt_q    <= intro_cnt_d;
            wave_num_q     <= wave_num_d;
            sched_active_q <= sched_active_d;
            wave_done_q    <= wave_done_d;
        end
    end

    esched_step_timer u_step_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .en        (timer_en_c),
        .clr       (timer_clr_c),
        .wave_num  (wave_num_q),
        .index     (ESchedCtr),
        .step_c    (step_unused_c)
    );

    assign sched_active = sched_active_q;
    assign wave_num     = wave_num_q;
    assign wave_done    = wave_done_q;

endmodule

// File: tb/tb_esched_ctrl.sv
module tb_esched_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       game_start;
    logic       pause;
    logic [7:0] alive_mask;
    logic [9:0] ESchedCtr;
    logic       sched_active;
    logic [3:0] wave_num;
    logic       wave_done;

    int n_vec  = 0;
    int n_miss = 0;

    esched_ctrl dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .game_start   (game_start),
        .pause        (pause),
        .alive_mask   (alive_mask),
        .ESchedCtr    (ESchedCtr),
        .sched_active (sched_active),
        .wave_num     (wave_num),
        .wave_done    (wave_done)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    // Behavioural model: phase plus count of unpaused RUN frames
    // phase 0 idle, 1 intro, 2 run, 3 clear
    int m_phase   = 0;
    int m_intro   = 0;
    int m_runfr   = 0;
    int m_wave    = 0;
    bit m_valid   = 0;

    function automatic int hold_of(input int w);
        int h;
        h = 16 - 2 * w;
        return (h < 4) ? 4 : h;
    endfunction

    always @(posedge frame_clk) begin
        if (Reset) begin
            m_phase = 0; m_intro = 0; m_runfr = 0; m_wave = 0; m_valid = 1;
        end else begin
            case (m_phase)
                0: if (game_start) begin m_phase = 1; m_intro = 0; end
                1: if (m_intro == 59) begin m_phase = 2; m_runfr = 0; end
                   else m_intro++;
                2: if (alive_mask == 8'h00) begin
                       m_phase = 3;
                       m_wave  = (m_wave < 15) ? m_wave + 1 : 15;
                   end else if (!pause) m_runfr++;
                default: begin m_phase = 1; m_intro = 0; end
            endcase
        end
        #1;
        if (m_valid) begin
            check("model_active", int'(sched_active), (m_phase == 2) ? 1 : 0);
            check("model_done",   int'(wave_done),    (m_phase == 3) ? 1 : 0);
            check("model_wave",   int'(wave_num),     m_wave);
            check("model_ctr",    int'(ESchedCtr),
                  (m_phase == 2) ? (m_runfr / hold_of(m_wave)) % 8 : 0);
        end
    end

    int holds[16];

    initial begin
        holds = '{16, 14, 12, 10, 8, 6, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        Reset = 1'b1; game_start = 1'b0; pause = 1'b0; alive_mask = 8'hFF;
        tick(2);
        Reset = 1'b0;
        tick(1);
        check("rst_ctr",    int'(ESchedCtr), 0);
        check("rst_active", int'(sched_active), 0);
        check("rst_wave",   int'(wave_num), 0);
        check("rst_done",   int'(wave_done), 0);

        // Start: RUN 60 frames after the start edge
        game_start = 1'b1; tick(1); game_start = 1'b0;
        check("intro_start", int'(sched_active), 0);
        tick(59);
        check("intro_last", int'(sched_active), 0);
        tick(1);
        check("run_rise", int'(sched_active), 1);
        check("run_ctr0", int'(ESchedCtr), 0);
        tick(15);
        check("hold16_end", int'(ESchedCtr), 0);
        tick(1);
        check("step1", int'(ESchedCtr), 1);

        // Wrap at frame 128 of RUN
        tick(111);
        check("ctr7", int'(ESchedCtr), 7);
        tick(1);
        check("wrap0", int'(ESchedCtr), 0);
        check("wrap_done", int'(wave_done), 0);

        // Pause 10 frames at index 3, hold 5
        tick(53);
        check("pre_pause", int'(ESchedCtr), 3);
        pause = 1'b1; tick(10); pause = 1'b0;
        check("paused", int'(ESchedCtr), 3);
        tick(10);
        check("delayed_hold", int'(ESchedCtr), 3);
        tick(1);
        check("delayed_step", int'(ESchedCtr), 4);

        // Empty mask with pause on a step-boundary frame -> CLEAR
        tick(15);
        alive_mask = 8'h00; pause = 1'b1;
        tick(1);
        check("clr_done",   int'(wave_done), 1);
        check("clr_wave",   int'(wave_num), 1);
        check("clr_ctr",    int'(ESchedCtr), 0);
        check("clr_active", int'(sched_active), 0);
        alive_mask = 8'hFF; pause = 1'b0;
        tick(1);
        check("done_pulse", int'(wave_done), 0);
        tick(59);
        check("w1_intro", int'(sched_active), 0);
        tick(1);
        check("w1_run", int'(sched_active), 1);
        tick(13);
        check("w1_hold_end", int'(ESchedCtr), 0);
        tick(1);
        check("w1_step", int'(ESchedCtr), 1);

        // Repeated clears: hold shrinks then clamps; wave saturates
        for (int w = 2; w <= 16; w++) begin
            alive_mask = 8'h00; tick(1);
            check("sat_wave", int'(wave_num), (w > 15) ? 15 : w);
            alive_mask = 8'hFF; tick(61);
            check("sat_run", int'(sched_active), 1);
            tick(holds[(w > 15) ? 15 : w] - 1);
            check("sat_hold_end", int'(ESchedCtr), 0);
            tick(1);
            check("sat_step", int'(ESchedCtr), 1);
        end

        // Fresh game to wave 2, reset mid-RUN at index 5
        Reset = 1'b1; tick(1); Reset = 1'b0;
        game_start = 1'b1; tick(1); game_start = 1'b0;
        tick(60);
        for (int k = 0; k < 2; k++) begin
            alive_mask = 8'h00; tick(1);
            alive_mask = 8'hFF; tick(61);
        end
        check("w2_wave", int'(wave_num), 2);
        tick(60);
        check("w2_ctr5", int'(ESchedCtr), 5);
        game_start = 1'b1; tick(5);
        check("gs_ignored_ctr",    int'(ESchedCtr), 5);
        check("gs_ignored_active", int'(sched_active), 1);
        game_start = 1'b0;
        Reset = 1'b1; tick(1);
        check("mid_rst_ctr",    int'(ESchedCtr), 0);
        check("mid_rst_active", int'(sched_active), 0);
        check("mid_rst_wave",   int'(wave_num), 0);
        check("mid_rst_done",   int'(wave_done), 0);
        Reset = 1'b0;
        tick(3);
        check("idle_stays", int'(sched_active), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
